// File: rtl/score_scan_ctrl.sv
// ---------------------------------------------------------------------------
// score_scan_ctrl
//
// Sequential score engine for the 2048 board. When the move/merge logic
// pulses board_valid, the 64-bit board is copied into a private snapshot and
// walked one tile per clock through a single shared adder. At the end of the
// walk the score, largest tile, empty-cell count and win flag are published
// together with a one-cycle done pulse.
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   board        in  64   tile codes, tile i = board[4i+3:4i]
//   board_valid  in   1   pulse: board holds a new settled position
//   clear        in   1   new-game pulse: abort scan, zero results
//   busy         out  1   high while a scan is in progress
//   done         out  1   one-cycle pulse when results are updated
//   score        out 32   sum of tile values of the last completed scan
//   max_tile     out  4   largest counted tile code of the last scan
//   empty_count  out  5   number of code-0 tiles in the last scan
//   win          out  1   max_tile >= WIN_CODE in the last scan
//   best_score   out 32   highest score seen since reset (optional)
//
// Optional feature macro: SCORE_BEST_TRACK_EN
//   defined   : best_score tracks max(best_score, score), cleared by rst_n only
//   undefined : best_score is tied to zero, no register or comparator built
// ---------------------------------------------------------------------------
module score_scan_ctrl #(
   parameter int N_TILES  = 16,
   parameter int TILE_W   = 4,
   parameter int WIN_CODE = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_TILES*TILE_W-1:0] board,
   input  logic                      board_valid,
   input  logic                      clear,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               score,
   output logic [TILE_W-1:0]         max_tile,
   output logic [4:0]                empty_count,
   output logic                      win,
   output logic [31:0]               best_score
);

   localparam int BOARD_W = N_TILES * TILE_W;
   localparam int IDX_W   = $clog2(N_TILES);
   // 16 tiles of at most 2^15 sum to 2^19, so 20 bits never overflow.
   localparam int ACC_W   = 20;

   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(N_TILES - 1);
   localparam logic [TILE_W-1:0] BLOCKED_CODE = TILE_W'(12);
   localparam logic [TILE_W-1:0] WIN_T        = TILE_W'(WIN_CODE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT               r_state;
   stateT               w_nextState;
   logic                w_load;
   logic                w_step;
   logic                w_commit;

   logic [BOARD_W-1:0]  r_snap;
   logic [IDX_W-1:0]    r_idx;
   logic [ACC_W-1:0]    r_acc;
   logic [TILE_W-1:0]   r_runMax;
   logic [4:0]          r_runEmpty;

   logic [31:0]         r_score;
   logic [TILE_W-1:0]   r_maxTile;
   logic [4:0]          r_emptyCount;
   logic                r_win;
   logic                r_done;

   logic [TILE_W-1:0]   w_code;
   logic                w_counted;
   logic [ACC_W-1:0]    w_tileVal;

   // Current tile under the scan pointer and its score contribution.
   // Empty (0) and blocked (12) cells add nothing and never set the max.
   assign w_code    = r_snap[TILE_W*r_idx +: TILE_W];
   assign w_counted = (w_code != '0) && (w_code != BLOCKED_CODE);

   always_comb begin
      w_tileVal = '0;
      if (w_counted) begin
         w_tileVal = ACC_W'(1) << w_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // clear overrides everything, including a simultaneous board_valid.
   // A new board in SCAN restarts the walk; a new board in DONE is taken
   // while the finished results are published, skipping IDLE.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_commit    = 1'b0;
      if (clear) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (board_valid) begin
                  w_load      = 1'b1;
                  w_nextState = SCAN;
               end
            end
            SCAN: begin
               if (board_valid) begin
                  w_load = 1'b1;
               end else begin
                  w_step = 1'b1;
                  if (r_idx == LAST_IDX) begin
                     w_nextState = DONE;
                  end
               end
            end
            DONE: begin
               w_commit = 1'b1;
               if (board_valid) begin
                  w_load      = 1'b1;
                  w_nextState = SCAN;
               end else begin
                  w_nextState = IDLE;
               end
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end
   end

   // Scan datapath: snapshot, pointer and running accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap     <= '0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_runMax   <= '0;
         r_runEmpty <= '0;
      end else if (w_load) begin
         r_snap     <= board;
         r_idx      <= '0;
         r_acc      <= '0;
         r_runMax   <= '0;
         r_runEmpty <= '0;
      end else if (w_step) begin
         r_acc <= r_acc + w_tileVal;
         r_idx <= r_idx + IDX_W'(1);
         if (w_counted && (w_code > r_runMax)) begin
            r_runMax <= w_code;
         end
         if (w_code == '0) begin
            r_runEmpty <= r_runEmpty + 5'd1;
         end
      end
   end

   // Published results only move on commit, clear or reset, so the display
   // keeps showing the previous position while a new one is being scanned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score      <= '0;
         r_maxTile    <= '0;
         r_emptyCount <= '0;
         r_win        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (clear) begin
            r_score      <= '0;
            r_maxTile    <= '0;
            r_emptyCount <= '0;
            r_win        <= 1'b0;
         end else if (w_commit) begin
            r_score      <= 32'(r_acc);
            r_maxTile    <= r_runMax;
            r_emptyCount <= r_runEmpty;
            r_win        <= (r_runMax >= WIN_T);
         end
      end
   end

`ifdef SCORE_BEST_TRACK_EN
   logic [31:0] r_bestScore;

   // High-score register survives clear so it persists across games.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bestScore <= '0;
      end else if (w_commit && !clear && (32'(r_acc) > r_bestScore)) begin
         r_bestScore <= 32'(r_acc);
      end
   end

   assign best_score = r_bestScore;
`else
   assign best_score = '0;
`endif

   assign busy        = (r_state == SCAN);
   assign done        = r_done;
   assign score       = r_score;
   assign max_tile    = r_maxTile;
   assign empty_count = r_emptyCount;
   assign win         = r_win;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_scan_ctrl
//
// Directed bench for score_scan_ctrl. Each step drives a board, waits for
// the done pulse within a bounded number of cycles and compares the results
// against hand-computed values. Honours SCORE_BEST_TRACK_EN for best_score.
// ---------------------------------------------------------------------------
module tb_score_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] board;
   logic        board_valid;
   logic        clear;
   logic        busy;
   logic        done;
   logic [31:0] score;
   logic [3:0]  max_tile;
   logic [4:0]  empty_count;
   logic        win;
   logic [31:0] best_score;

   int nAssert = 0;
   int nFail   = 0;
   int lat;
   int busyCnt;

   always #5 clk = ~clk;

   score_scan_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .board       (board),
      .board_valid (board_valid),
      .clear       (clear),
      .busy        (busy),
      .done        (done),
      .score       (score),
      .max_tile    (max_tile),
      .empty_count (empty_count),
      .win         (win),
      .best_score  (best_score)
   );

   // Expected best_score given the high score reached so far.
   function automatic logic [31:0] bestExp(input logic [31:0] v);
`ifdef SCORE_BEST_TRACK_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs around the next rising edge, returns 1 time
   // unit after that edge, and scrambles board so only the snapshot matters.
   task automatic applyStimulus(input logic [63:0] brd, input logic vld,
                                input logic clr);
      @(negedge clk);
      board       = brd;
      board_valid = vld;
      clear       = clr;
      @(posedge clk);
      #1;
      board_valid = 1'b0;
      clear       = 1'b0;
      board       = ~brd;
   endtask

   // Counts edges (current sample is 0) until done, bounded at 40 cycles.
   task automatic waitDone(output int latency, output int busyCycles);
      latency    = -1;
      busyCycles = 0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) begin
            latency = k;
            break;
         end
         if (busy === 1'b1) busyCycles++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scanAndCheck(input string tag, input logic [63:0] brd,
                               input logic [31:0] expScore, input logic [3:0] expMax,
                               input logic [4:0] expEmpty, input logic expWin);
      int l;
      int b;
      applyStimulus(brd, 1'b1, 1'b0);
      waitDone(l, b);
      checkOutput({tag, ".latency"}, l, 17);
      checkOutput({tag, ".busyCycles"}, b, 16);
      checkOutput({tag, ".score"}, score, expScore);
      checkOutput({tag, ".max_tile"}, 32'(max_tile), 32'(expMax));
      checkOutput({tag, ".empty_count"}, 32'(empty_count), 32'(expEmpty));
      checkOutput({tag, ".win"}, 32'(win), 32'(expWin));
      @(posedge clk);
      #1;
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
      checkOutput({tag, ".scoreHold"}, score, expScore);
   endtask

   initial begin
      rst_n       = 1'b0;
      board       = '0;
      board_valid = 1'b0;
      clear       = 1'b0;
      #1;
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.score", score, 32'd0);
      checkOutput("reset.max_tile", 32'(max_tile), 32'd0);
      checkOutput("reset.empty_count", 32'(empty_count), 32'd0);
      checkOutput("reset.win", 32'(win), 32'd0);
      checkOutput("reset.best", best_score, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      scanAndCheck("zeros", 64'h0, 32'd0, 4'd0, 5'd16, 1'b0);
      scanAndCheck("twoTiles", 64'h21, 32'd6, 4'd2, 5'd14, 1'b0);
      scanAndCheck("winBlocked", 64'h0000_0000_C000_B000, 32'd2048, 4'd11, 5'd14, 1'b1);
      checkOutput("best.after2048", best_score, bestExp(32'd2048));
      scanAndCheck("twoTilesAgain", 64'h21, 32'd6, 4'd2, 5'd14, 1'b0);
      checkOutput("best.after6", best_score, bestExp(32'd2048));

      applyStimulus(64'h0, 1'b0, 1'b1);
      checkOutput("clear.score", score, 32'd0);
      checkOutput("clear.max_tile", 32'(max_tile), 32'd0);
      checkOutput("clear.empty_count", 32'(empty_count), 32'd0);
      checkOutput("clear.win", 32'(win), 32'd0);
      checkOutput("clear.busy", 32'(busy), 32'd0);
      checkOutput("clear.best", best_score, bestExp(32'd2048));

      scanAndCheck("allBlocked", 64'hCCCC_CCCC_CCCC_CCCC, 32'd0, 4'd0, 5'd0, 1'b0);
      scanAndCheck("tile1024", 64'hA, 32'd1024, 4'd10, 5'd15, 1'b0);
      scanAndCheck("allF", 64'hFFFF_FFFF_FFFF_FFFF, 32'h0008_0000, 4'd15, 5'd0, 1'b1);
      checkOutput("best.afterAllF", best_score, bestExp(32'h0008_0000));

      // Abort: board A restarted by board B eight cycles in.
      applyStimulus(64'h21, 1'b1, 1'b0);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort.holdScore", score, 32'h0008_0000);
      checkOutput("abort.busy", 32'(busy), 32'd1);
      checkOutput("abort.noDone", 32'(done), 32'd0);
      applyStimulus(64'h0000_0000_C000_B000, 1'b1, 1'b0);
      waitDone(lat, busyCnt);
      checkOutput("abort.latency", lat, 17);
      checkOutput("abort.busyCycles", busyCnt, 16);
      checkOutput("abort.score", score, 32'd2048);
      checkOutput("abort.empty_count", 32'(empty_count), 32'd14);

      // New board presented during the DONE cycle.
      applyStimulus(64'h21, 1'b1, 1'b0);
      repeat (16) begin
         @(posedge clk);
         #1;
      end
      checkOutput("doneCycle.inDoneBusy", 32'(busy), 32'd0);
      @(negedge clk);
      board       = 64'hB000;
      board_valid = 1'b1;
      @(posedge clk);
      #1;
      board_valid = 1'b0;
      board       = 64'h0;
      checkOutput("doneCycle.done", 32'(done), 32'd1);
      checkOutput("doneCycle.score", score, 32'd6);
      checkOutput("doneCycle.busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      waitDone(lat, busyCnt);
      checkOutput("doneCycle.latency", lat, 16);
      checkOutput("doneCycle.score2", score, 32'd2048);
      checkOutput("doneCycle.max_tile", 32'(max_tile), 32'd11);
      checkOutput("doneCycle.empty_count", 32'(empty_count), 32'd15);
      checkOutput("doneCycle.win", 32'(win), 32'd1);

      // Clear in the middle of a scan: no results ever appear.
      applyStimulus(64'hF, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      applyStimulus(64'h0, 1'b0, 1'b1);
      checkOutput("midClear.busy", 32'(busy), 32'd0);
      checkOutput("midClear.score", score, 32'd0);
      waitDone(lat, busyCnt);
      checkOutput("midClear.noDone", lat, -1);

      // Clear together with board_valid: board dropped.
      applyStimulus(64'hF, 1'b1, 1'b1);
      checkOutput("clearAndValid.busy", 32'(busy), 32'd0);
      waitDone(lat, busyCnt);
      checkOutput("clearAndValid.noDone", lat, -1);
      checkOutput("clearAndValid.score", score, 32'd0);
      checkOutput("clearAndValid.best", best_score, bestExp(32'h0008_0000));

      scanAndCheck("afterClear", 64'hF, 32'd32768, 4'd15, 5'd15, 1'b1);
      checkOutput("best.afterClearScan", best_score, bestExp(32'h0008_0000));

      // Asynchronous reset mid-cycle clears everything including best_score.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset.score", score, 32'd0);
      checkOutput("asyncReset.max_tile", 32'(max_tile), 32'd0);
      checkOutput("asyncReset.win", 32'(win), 32'd0);
      checkOutput("asyncReset.best", best_score, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
